// File: rtl/add16_pkg.sv
// Shared width constant and word type for the 16-bit adder slice.
package add_pkg;

    localparam int ADD_W = 16;

    typedef logic [ADD_W-1:0] word_t;

endpackage : add_pkg

// File: rtl/add16_if.sv
// Operand/result bundle between the adder and its consumers.
// The slave side computes the results; the master side supplies the addends.
interface add16_if;
    import add_pkg::*;

    word_t a;
    word_t b;
    word_t out;
    logic  cout;
    word_t out_q;
    logic  cout_q;

    modport master (
        output a,
        output b,
        input  out,
        input  cout,
        input  out_q,
        input  cout_q
    );

    modport slave (
        input  a,
        input  b,
        output out,
        output cout,
        output out_q,
        output cout_q
    );

endinterface : add16_if

// File: rtl/add16_full_adder.sv
// One-bit full adder cell, written gate-style to match the rest of the ALU datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic halfSum;

    // Propagate term is shared by the sum and the carry.
    assign halfSum = a ^ b;
    assign sum     = halfSum ^ cin;
    assign cout    = (a & b) | (cin & halfSum);

endmodule : full_adder

// File: rtl/add16.sv
// 16-bit ripple-carry adder with a combinational result and a one-cycle registered copy.
// The combinational path never touches clk or reset, so it stays valid with the clock stopped.
module add16
    import add_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    add16_if.slave bus
);

    logic [ADD_W:0] carryChain;
    word_t          sumWord;

    word_t          sum_d;
    word_t          sum_q;
    logic           carry_d;
    logic           carry_q;

    // Bit 0 is a full adder with its carry-in tied low, which acts as a half adder.
    assign carryChain[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < ADD_W; i++) begin : gRipple
            full_adder uFullAdder (
                .a    (bus.a[i]),
                .b    (bus.b[i]),
                .cin  (carryChain[i]),
                .sum  (sumWord[i]),
                .cout (carryChain[i+1])
            );
        end
    endgenerate

    assign bus.out  = sumWord;
    assign bus.cout = carryChain[ADD_W];

    // Next-state for the pipeline copy is simply the live combinational result.
    always_comb begin
        sum_d   = sumWord;
        carry_d = carryChain[ADD_W];
    end

    // Capture the result each edge; reset wins and clears only this registered copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign bus.out_q  = sum_q;
    assign bus.cout_q = carry_q;

endmodule : add16

// File: tb/tb_add16.sv
// Directed bench for add16: combinational vectors with the clock stopped,
// then the registered path tracked through a queue of expected results.
module tb_add16;
    import add_pkg::*;

    typedef struct {
        word_t sum;
        logic  carry;
        string tag;
    } expected_t;

    logic clk = 1'b0;
    logic clkEn = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    expected_t scoreboard[$];

    add16_if bus ();

    add16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock stays static until the combinational checks are done.
    initial begin
        wait (clkEn);
        forever #5 clk = ~clk;
    end

    // Hard stop so a broken design can never hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare the combinational outputs against bench-computed values.
    task automatic checkComb(input string tag, input word_t expSum, input logic expCarry);
        checks++;
        assert (bus.out === expSum) else begin
            errors++;
            $error("[TB] FAIL %s out actual=%h required=%h", tag, bus.out, expSum);
        end
        checks++;
        assert (bus.cout === expCarry) else begin
            errors++;
            $error("[TB] FAIL %s cout actual=%b required=%b", tag, bus.cout, expCarry);
        end
    endtask

    // Drive operands and reset, record what the registers must hold after the next edge, then take that edge.
    task automatic applyStimulus(input string tag, input word_t opA, input word_t opB, input logic rst);
        expected_t e;
        logic [ADD_W:0] full;
        bus.a = opA;
        bus.b = opB;
        reset = rst;
        full = {1'b0, opA} + {1'b0, opB};
        e.sum   = rst ? '0 : full[ADD_W-1:0];
        e.carry = rst ? 1'b0 : full[ADD_W];
        e.tag   = tag;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expectation and compare it with the registered outputs.
    task automatic checkOutput();
        expected_t e;
        checks++;
        assert (scoreboard.size() > 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty actual=0 required=nonzero");
        end
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checks++;
            assert (bus.out_q === e.sum) else begin
                errors++;
                $error("[TB] FAIL %s out_q actual=%h required=%h", e.tag, bus.out_q, e.sum);
            end
            checks++;
            assert (bus.cout_q === e.carry) else begin
                errors++;
                $error("[TB] FAIL %s cout_q actual=%b required=%b", e.tag, bus.cout_q, e.carry);
            end
        end
    endtask

    initial begin
        word_t ra;
        word_t rb;
        logic [ADD_W:0] model;

        reset = 1'b0;
        bus.a = '0;
        bus.b = '0;

        $display("[TB] combinational vectors, clock stopped");
        bus.a = 16'h0000; bus.b = 16'h0000; #1; checkComb("zero_zero", 16'h0000, 1'b0);
        bus.a = 16'h0000; bus.b = 16'hFFFF; #1; checkComb("zero_ffff", 16'hFFFF, 1'b0);
        bus.a = 16'hFFFF; bus.b = 16'hFFFF; #1; checkComb("ffff_ffff", 16'hFFFE, 1'b1);
        bus.a = 16'hAAAA; bus.b = 16'h5555; #1; checkComb("aaaa_5555", 16'hFFFF, 1'b0);
        bus.a = 16'h3CC3; bus.b = 16'h0FF0; #1; checkComb("3cc3_0ff0", 16'h4CB3, 1'b0);
        bus.a = 16'h1234; bus.b = 16'h9876; #1; checkComb("1234_9876", 16'hAAAA, 1'b0);
        bus.a = 16'hFFFF; bus.b = 16'h0001; #1; checkComb("ripple_all", 16'h0000, 1'b1);
        bus.a = 16'h8000; bus.b = 16'h8000; #1; checkComb("msb_carry", 16'h0000, 1'b1);

        // Reset must not disturb the combinational result.
        reset = 1'b1;
        bus.a = 16'h0102; bus.b = 16'h0304; #1; checkComb("comb_in_reset", 16'h0406, 1'b0);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) begin
            ra = word_t'($urandom);
            rb = word_t'($urandom);
            model = {1'b0, ra} + {1'b0, rb};
            bus.a = ra; bus.b = rb; #1;
            checkComb("comb_random", model[ADD_W-1:0], model[ADD_W]);
        end

        $display("[TB] registered path");
        clkEn = 1'b1;

        applyStimulus("reset_first", 16'h1234, 16'h1111, 1'b1);
        checkOutput();

        applyStimulus("capture_wrap", 16'hFFFF, 16'hFFFF, 1'b0);
        checkOutput();

        applyStimulus("reset_again", 16'hFFFF, 16'hFFFF, 1'b1);
        checkOutput();
        checkComb("comb_during_reset", 16'hFFFE, 1'b1);

        applyStimulus("capture_ripple", 16'hFFFF, 16'h0001, 1'b0);
        checkOutput();

        for (int k = 0; k < 8; k++) begin
            applyStimulus("capture_random", word_t'($urandom), word_t'($urandom), 1'b0);
            checkOutput();
        end

        applyStimulus("capture_plain", 16'h3CC3, 16'h0FF0, 1'b0);
        checkOutput();

        checks++;
        assert (scoreboard.size() == 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_drain actual=%0d required=0", scoreboard.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_add16
